dmem_arbiter: RTL and testbench

//   Shares the single-port data memory between the CPU MEM stage and a DMA/debug

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data memory between the CPU MEM stage and a DMA port
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_ack_o,
  output logic              err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // MEM_LAT is limited to 1..4, so a 2-bit down-counter covers the BUSY phase
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);
  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DMA  = 1'b1;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;
  logic                r_last_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dma_rdata;

  logic                w_grant;
  logic                w_grant_dma;
  logic                w_misaligned;
  logic                w_access;
  logic                w_last_busy;
  logic [DATA_W-1:0]   w_rd_value;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_dma  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          w_grant      = 1'b1;
          // On a tie the side that did not win last time gets the memory
          w_grant_dma  = dma_req_i && (!cpu_req_i || (r_last_grant == OWN_CPU));
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == 2'd0) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_misaligned = (r_addr[1:0] != 2'b00);
  assign w_access     = (r_state == S_BUSY) && !w_misaligned;
  assign w_last_busy  = (r_state == S_BUSY) && (r_cnt == 2'd0);
  assign w_rd_value   = w_misaligned ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_owner      <= OWN_CPU;
      r_last_grant <= OWN_DMA;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= 2'd0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner      <= w_grant_dma;
        r_last_grant <= w_grant_dma;
        r_we         <= w_grant_dma ? dma_we_i    : cpu_we_i;
        r_addr       <= w_grant_dma ? dma_addr_i  : cpu_addr_i;
        r_wdata      <= w_grant_dma ? dma_wdata_i : cpu_wdata_i;
        r_cnt        <= CNT_INIT;
      end else if ((r_state == S_BUSY) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      // Writes leave the owner's read-data register untouched
      if (w_last_busy && !r_we) begin
        if (r_owner == OWN_DMA) begin
          r_dma_rdata <= w_rd_value;
        end else begin
          r_cpu_rdata <= w_rd_value;
        end
      end
    end
  end

  assign mem_en_o    = w_access;
  assign mem_we_o    = w_access && r_we;
  assign mem_addr_o  = w_access ? r_addr : '0;
  assign mem_wdata_o = (w_access && r_we) ? r_wdata : '0;

  assign cpu_rdata_o = r_cpu_rdata;
  assign dma_rdata_o = r_dma_rdata;
  assign cpu_stall_o = cpu_req_i && !((r_state == S_RESP) && (r_owner == OWN_CPU));
  assign dma_ack_o   = (r_state == S_RESP) && (r_owner == OWN_DMA);
  assign err_o       = (r_state == S_RESP) && w_misaligned;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        mem_init;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic        st1, st3, ak1, ak3, er1, er3, me1, me3, mwe1, mwe3;
  logic [31:0] crd1, crd3, drd1, drd3, ma1, ma3, mw1, mw3, mr1, mr3;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(crd1), .cpu_stall_o(st1),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(drd1), .dma_ack_o(ak1), .err_o(er1),
    .mem_en_o(me1), .mem_we_o(mwe1), .mem_addr_o(ma1), .mem_wdata_o(mw1), .mem_rdata_i(mr1)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(crd3), .cpu_stall_o(st3),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(drd3), .dma_ack_o(ak3), .err_o(er3),
    .mem_en_o(me3), .mem_we_o(mwe3), .mem_addr_o(ma3), .mem_wdata_o(mw3), .mem_rdata_i(mr3)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 2) ? 32'd10 : 32'(i * 7 + 3);
  endfunction

  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= init_val(i);
        mem3[i] <= init_val(i);
      end
    end else begin
      if (me1 && mwe1) mem1[ma1[7:2]] <= mw1;
      if (me3 && mwe3) mem3[ma3[7:2]] <= mw3;
    end
  end
  assign mr1 = mem1[ma1[7:2]];
  assign mr3 = mem3[ma3[7:2]];

  logic        w_stall, w_ack, w_err, w_en, w_mwe;
  logic [31:0] w_crd, w_drd, w_maddr, w_mwd;
  assign w_stall = sel ? st3  : st1;
  assign w_ack   = sel ? ak3  : ak1;
  assign w_err   = sel ? er3  : er1;
  assign w_en    = sel ? me3  : me1;
  assign w_mwe   = sel ? mwe3 : mwe1;
  assign w_crd   = sel ? crd3 : crd1;
  assign w_drd   = sel ? drd3 : drd1;
  assign w_maddr = sel ? ma3  : ma1;
  assign w_mwd   = sel ? mw3  : mw1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    total++;
    if (act > lim) begin
      bad++;
      $display("FAIL %s: got %0d want <= %0d", name, act, lim);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen at cycle %0d, expected none", name, cyc);
  endtask

  // Reference model: flat memory image plus each port's last read result
  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] cpu_last, dma_last;

  localparam logic [7:0] TAG_C = 8'h43;
  localparam logic [7:0] TAG_D = 8'h44;
  logic [7:0] order_q[$];
  int         order_cyc[$];
  int         en_cnt, enwe_cnt;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_req && !w_stall) begin
        if (cpu_q.size() == 0) begin
          fail_event("cpu_unexpected_release");
        end else begin
          exp_t e;
          e = cpu_q.pop_front();
          check("cpu_rdata", w_crd, e.data);
          check("cpu_err", {31'd0, w_err}, {31'd0, e.err});
        end
        order_q.push_back(TAG_C);
        order_cyc.push_back(cyc);
      end
      if (w_ack) begin
        if (dma_q.size() == 0) begin
          fail_event("dma_unexpected_ack");
        end else begin
          exp_t e;
          e = dma_q.pop_front();
          check("dma_rdata", w_drd, e.data);
          check("dma_err", {31'd0, w_err}, {31'd0, e.err});
        end
        order_q.push_back(TAG_D);
        order_cyc.push_back(cyc);
      end
      if (w_err && !(cpu_req && !w_stall) && !w_ack) fail_event("err_stray");
      if (w_en && (w_maddr[1:0] != 2'b00)) fail_event("mem_en_misaligned");
      if (w_en) en_cnt++;
      if (w_en && w_mwe) enwe_cnt++;
    end
  end

  function automatic int cur_lat();
    return sel ? 3 : 1;
  endfunction

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input bit hold, output int n);
    exp_t e;
    n = 0;
    cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
    e.err = (addr[1:0] != 2'b00);
    if (!we) cpu_last = e.err ? 32'd0 : ref_mem[addr[7:2]];
    else if (!e.err) ref_mem[addr[7:2]] = data;
    e.data = cpu_last;
    cpu_q.push_back(e);
    while (1) begin
      @(negedge clk);
      if (!w_stall) break;
      n++;
      if (n > 60) begin
        fail_event("cpu_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic dma_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input bit hold, output int n);
    exp_t e;
    n = 0;
    dma_we = we; dma_addr = addr; dma_wdata = data; dma_req = 1'b1;
    e.err = (addr[1:0] != 2'b00);
    if (!we) dma_last = e.err ? 32'd0 : ref_mem[addr[7:2]];
    else if (!e.err) ref_mem[addr[7:2]] = data;
    e.data = dma_last;
    dma_q.push_back(e);
    while (1) begin
      @(negedge clk);
      if (w_ack) break;
      n++;
      if (n > 60) begin
        fail_event("dma_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) dma_req = 1'b0;
  endtask

  task automatic do_reset(input logic s);
    sel = s; rst_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_init = 1'b0; rst_n = 1'b1;
    cpu_q.delete(); dma_q.delete();
    cpu_last = '0; dma_last = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, n2;
    sel = 1'b0; rst_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; dma_req = 1'b0;
    en_cnt = 0; enwe_cnt = 0;

    // ---------------- MEM_LAT = 1 ----------------
    do_reset(1'b0);
    @(negedge clk);
    check("rst_stall", {31'd0, w_stall}, 32'd0);
    check("rst_ack",   {31'd0, w_ack},   32'd0);
    check("rst_err",   {31'd0, w_err},   32'd0);
    check("rst_mem_ctl", {30'd0, w_en, w_mwe}, 32'd0);
    check("rst_mem_addr", w_maddr, 32'd0);
    check("rst_mem_wdata", w_mwd, 32'd0);
    check("rst_cpu_rdata", w_crd, 32'd0);
    check("rst_dma_rdata", w_drd, 32'd0);
    @(posedge clk); #1;

    cpu_access(1'b0, 32'd8, 32'd0, 1'b0, n);
    check("t1_stall_cycles", 32'(n), 32'd2);

    do_reset(1'b0);
    order_q.delete(); order_cyc.delete();
    fork
      cpu_access(1'b0, 32'd8,    32'd0, 1'b0, n);
      dma_access(1'b0, 32'h44,   32'd0, 1'b0, n2);
    join
    check("t2_first_is_cpu", {24'd0, order_q[0]}, {24'd0, TAG_C});
    check("t2_dma_after_cpu", 32'(order_cyc[1] - order_cyc[0]), 32'd3);

    order_q.delete(); order_cyc.delete();
    fork
      begin
        int nc;
        for (int k = 0; k < 4; k++)
          cpu_access(1'(k % 2), 32'(k * 4), 32'(k + 100), (k < 3), nc);
      end
      begin
        int nd;
        for (int k = 0; k < 4; k++)
          dma_access(1'((k + 1) % 2), 32'(64 + k * 4), 32'(k + 200), (k < 3), nd);
      end
    join
    check("t3_grants", 32'(order_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < order_q.size(); k++) begin
      check("t3_order", {24'd0, order_q[k]}, {24'd0, ((k % 2) != 0) ? TAG_D : TAG_C});
      if (k > 0) check("t3_spacing", 32'(order_cyc[k] - order_cyc[k-1]), 32'd3);
    end

    // ---------------- MEM_LAT = 3 ----------------
    do_reset(1'b1);
    enwe_cnt = 0;
    dma_access(1'b1, 32'h14, 32'd77, 1'b0, n);
    check("t4_ack_cycle", 32'(n), 32'd4);
    check("t4_en_we_cycles", 32'(enwe_cnt), 32'd3);
    check("t4_mem5", mem3[5], 32'd77);

    cpu_access(1'b0, 32'd8, 32'd0, 1'b0, n);
    en_cnt = 0;
    cpu_access(1'b0, 32'd6, 32'd0, 1'b0, n);
    check("t5_mem_en_cycles", 32'(en_cnt), 32'd0);

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_busy_before_reset", {31'd0, w_en}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; cpu_req = 1'b0;
    cpu_last = '0; dma_last = '0;
    @(negedge clk);
    check("t6_mem_en_after", {31'd0, w_en}, 32'd0);
    check("t6_ack_after", {31'd0, w_ack}, 32'd0);
    check("t6_cpu_rdata_cleared", w_crd, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    order_q.delete(); order_cyc.delete();
    fork
      cpu_access(1'b0, 32'd8,  32'd0, 1'b0, n);
      dma_access(1'b0, 32'h48, 32'd0, 1'b0, n2);
    join
    check("t6_tie_to_cpu", {24'd0, order_q[0]}, {24'd0, TAG_C});

    fork
      begin
        int g, nc;
        logic w;
        logic [31:0] a;
        for (int k = 0; k < 30; k++) begin
          g = $urandom_range(0, 3);
          repeat (g) begin @(posedge clk); #1; end
          w = 1'($urandom_range(0, 1));
          a = 32'($urandom_range(0, 15)) << 2;
          if (!w && ($urandom_range(0, 5) == 0)) a = a + 32'($urandom_range(1, 3));
          cpu_access(w, a, $urandom, 1'b0, nc);
          check_le("rand_cpu_latency", nc, 2 * cur_lat() + 3);
        end
      end
      begin
        int g, nd;
        logic w;
        logic [31:0] a;
        for (int k = 0; k < 30; k++) begin
          g = $urandom_range(0, 3);
          repeat (g) begin @(posedge clk); #1; end
          w = 1'($urandom_range(0, 1));
          a = 32'($urandom_range(16, 31)) << 2;
          if (!w && ($urandom_range(0, 5) == 0)) a = a + 32'($urandom_range(1, 3));
          dma_access(w, a, $urandom, 1'b0, nd);
          check_le("rand_dma_latency", nd, 2 * cur_lat() + 3);
        end
      end
    join
    repeat (4) @(posedge clk);
    check("cpu_q_left", 32'(cpu_q.size()), 32'd0);
    check("dma_q_left", 32'(dma_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
